branch_predictor: RTL and testbench
===================================

# branch_predictor

- Fetch-side direction and target predictor; sits directly upstream of the branch manager.
- Consumes the fetch PC; one cycle later supplies `pred_taken`, `pred_pc` and `pred_addr`, which the branch manager compares against the resolved outcome.
- Trained from the resolved outcome (`update_*`). Direct-mapped table: per-entry valid bit, tag, target and 2-bit saturating counter.

## Interface
- `WordSize`, 32, width of PC and target.
- `Entries`, 16, number of table entries; power of two, at least 2. `IdxW = $clog2(Entries)`.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous reset, active-high. Reset is synchronous and active-high.
- `lookup_en`  input  1  sample `lookup_pc` this cycle.
- `lookup_pc`  input  WordSize  fetch PC to predict.
- `pred_valid`  output  1  prediction outputs correspond to a lookup.
- `pred_taken`  output  1  predicted direction.
- `pred_pc`  output  WordSize  registered copy of the looked-up PC.
- `pred_addr`  output  WordSize  predicted next PC.
- `update_valid`  input  1  a resolved branch is presented this cycle.
- `update_pc`  input  WordSize  PC of the resolved branch.
- `update_taken`  input  1  resolved direction.
- `update_target`  input  WordSize  resolved taken target.

## Operation
- Index = `pc[IdxW+1:2]`; tag = `pc[WordSize-1:IdxW+2]`. Bits `[1:0]` are ignored on both ports.
- Hit = entry valid and stored tag equals PC tag.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff hit and `ctr[1]`.
- Lookup, when `lookup_en` = 1, registers at the edge:
  - `pred_valid` ← 1; `pred_pc` ← `lookup_pc`.
  - `pred_taken` ← hit & `ctr[1]`.
  - `pred_addr` ← stored target if predicted taken, else `lookup_pc + 4`. Addition is modulo 2^WordSize.
- `lookup_en` = 0: `pred_valid` ← 0; `pred_taken`, `pred_pc` and `pred_addr` hold their previous values.
- Update, when `update_valid` = 1:
  - Hit, taken: counter increments, saturating at 11; target ← `update_target`.
  - Hit, not taken: counter decrements, saturating at 00; target unchanged.
  - Miss, taken: allocate and overwrite any resident entry. valid ← 1, tag ← update tag, target ← `update_target`, counter ← 10.
  - Miss, not taken: table unchanged.
- Simultaneous lookup and update:
  - Different indices: both proceed independently.
  - Same index: governed by `BP_BYPASS_EN` (see Configuration).
- Only one update per cycle; no back-pressure on either port.

## Timing
- Lookup latency: 1 cycle, `lookup_pc` at edge N → outputs valid after edge N.
- Update takes effect at the edge where `update_valid` is sampled. A lookup in any later cycle sees the new state.
- Reset, at any rising edge with `rst` = 1, including mid-stream:
  - All valid bits ← 0; all counters ← 01; targets and tags ← 0.
  - `pred_valid`, `pred_taken` ← 0; `pred_pc`, `pred_addr` ← 0.
  - Lookups and updates in the reset cycle are discarded.
- First lookup after reset always misses → `pred_taken` = 0, `pred_addr` = PC + 4.

## Configuration
- Macro `BP_BYPASS_EN`.
- Defined: a same-cycle update to the lookup's index is forwarded. The prediction is computed from the post-update entry state: hit, counter and target as written that edge.
- Undefined: read-before-write. The lookup uses the entry state before the edge; the update is visible from the next lookup.

## Test plan
- Reset, then lookup 0x100 → `pred_valid`=1, `pred_taken`=0, `pred_pc`=0x100, `pred_addr`=0x104.
- Update (0x100, taken, 0x200), then lookup 0x100 → `pred_taken`=1, `pred_addr`=0x200. Counter = 10.
- Training at 0x100:
  - Three taken updates saturate the counter at 11.
  - Then one not-taken → still predicts taken to 0x200.
  - A second not-taken → counter 01, `pred_addr`=0x104.
- Alias with Entries=16: allocate 0x100 taken→0x200, then update 0x140 taken→0x300.
  - Lookup 0x100 → miss, 0x104.
  - Lookup 0x140 → taken, 0x300.
- Same-cycle update (0x180, taken, 0x400) and lookup 0x180 on an empty entry:
  - With `BP_BYPASS_EN` → taken, 0x400.
  - Without → not taken, 0x184; the following lookup → taken, 0x400.
- Reset asserted for one cycle after training 0x100 → next lookup 0x100 returns `pred_taken`=0, `pred_addr`=0x104. All outputs are 0 during the reset cycle.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped fetch predictor: per-entry valid, tag, target and 2-bit counter.
// Define BP_BYPASS_EN to forward a same-cycle update into a lookup of the same index.
module branch_predictor #(
    parameter int WordSize = 32,
    parameter int Entries  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_en,
    input  logic [WordSize-1:0] lookup_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_pc,
    output logic [WordSize-1:0] pred_addr,
    input  logic                update_valid,
    input  logic [WordSize-1:0] update_pc,
    input  logic                update_taken,
    input  logic [WordSize-1:0] update_target
);
    localparam int IdxW = $clog2(Entries);
    localparam int TagW = WordSize - 2 - IdxW;

    logic                valid_q [Entries];
    logic                valid_d [Entries];
    logic [TagW-1:0]     tag_q   [Entries];
    logic [TagW-1:0]     tag_d   [Entries];
    logic [WordSize-1:0] tgt_q   [Entries];
    logic [WordSize-1:0] tgt_d   [Entries];
    logic [1:0]          ctr_q   [Entries];
    logic [1:0]          ctr_d   [Entries];

    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [WordSize-1:0] pred_pc_q, pred_pc_d;
    logic [WordSize-1:0] pred_addr_q, pred_addr_d;

    // Drop the byte offset once so every remaining bit feeds index or tag.
    logic [WordSize-3:0] upd_word, lk_word;
    logic [IdxW-1:0]     upd_idx, lk_idx;
    logic [TagW-1:0]     upd_tag, lk_tag;
    logic                upd_hit, lk_hit;
    logic                lk_valid;
    logic [TagW-1:0]     lk_etag;
    logic [WordSize-1:0] lk_tgt;
    logic [1:0]          lk_ctr;

    assign upd_word = update_pc[WordSize-1:2];
    assign lk_word  = lookup_pc[WordSize-1:2];
    assign upd_idx  = upd_word[IdxW-1:0];
    assign upd_tag  = upd_word[WordSize-3:IdxW];
    assign lk_idx   = lk_word[IdxW-1:0];
    assign lk_tag   = lk_word[WordSize-3:IdxW];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (update_valid) begin
            if (upd_hit) begin
                if (update_taken) begin
                    ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    tgt_d[upd_idx] = update_target;
                end else begin
                    ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (update_taken) begin
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = update_target;
                ctr_d[upd_idx]   = 2'b10;
            end
        end
    end

    always_comb begin
`ifdef BP_BYPASS_EN
        lk_valid = valid_d[lk_idx];
        lk_etag  = tag_d[lk_idx];
        lk_tgt   = tgt_d[lk_idx];
        lk_ctr   = ctr_d[lk_idx];
`else
        lk_valid = valid_q[lk_idx];
        lk_etag  = tag_q[lk_idx];
        lk_tgt   = tgt_q[lk_idx];
        lk_ctr   = ctr_q[lk_idx];
`endif
        lk_hit       = lk_valid && (lk_etag == lk_tag);
        pred_valid_d = lookup_en;
        pred_taken_d = pred_taken_q;
        pred_pc_d    = pred_pc_q;
        pred_addr_d  = pred_addr_q;
        if (lookup_en) begin
            pred_taken_d = lk_hit && lk_ctr[1];
            pred_pc_d    = lookup_pc;
            pred_addr_d  = (lk_hit && lk_ctr[1]) ? lk_tgt : lookup_pc + WordSize'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
            pred_addr_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            tgt_q        <= tgt_d;
            ctr_q        <= ctr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
            pred_addr_q  <= pred_addr_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_pc    = pred_pc_q;
    assign pred_addr  = pred_addr_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (Entries=16); expectations follow BP_BYPASS_EN.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_pc, pred_addr;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predictor #(.WordSize(32), .Entries(16)) dut (
        .clk(clk), .rst(rst),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_pc(pred_pc), .pred_addr(pred_addr),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic cyc(input logic le, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt);
        lookup_en     = le;
        lookup_pc     = lpc;
        update_valid  = uv;
        update_pc     = upc;
        update_taken  = ut;
        update_target = utgt;
        @(posedge clk);
        #1;
    endtask

    task automatic lk(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic up(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        cyc(1'b0, 32'h0, 1'b1, pc, t, tgt);
    endtask

    task automatic pred(input string tag, input logic t, input logic [31:0] addr);
        chk({tag, ".valid"}, {31'h0, pred_valid}, 32'h1);
        chk({tag, ".taken"}, {31'h0, pred_taken}, {31'h0, t});
        chk({tag, ".addr"}, pred_addr, addr);
    endtask

    initial begin
        rst = 1'b1;
        cyc(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst.valid", {31'h0, pred_valid}, 32'h0);
        chk("rst.taken", {31'h0, pred_taken}, 32'h0);
        chk("rst.pc", pred_pc, 32'h0);
        chk("rst.addr", pred_addr, 32'h0);
        rst = 1'b0;

        // Cold lookup misses; the update presented during reset must be gone.
        lk(32'h100);
        pred("cold", 1'b0, 32'h104);
        chk("cold.pc", pred_pc, 32'h100);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("idle.valid", {31'h0, pred_valid}, 32'h0);
        chk("idle.pc_hold", pred_pc, 32'h100);
        chk("idle.addr_hold", pred_addr, 32'h104);

        up(32'h100, 1'b1, 32'h200);
        lk(32'h100);
        pred("alloc", 1'b1, 32'h200);

        up(32'h100, 1'b1, 32'h200);
        up(32'h100, 1'b1, 32'h200);
        up(32'h100, 1'b0, 32'h0);
        lk(32'h100);
        pred("sat_nt1", 1'b1, 32'h200);
        up(32'h100, 1'b0, 32'h0);
        lk(32'h100);
        pred("sat_nt2", 1'b0, 32'h104);

        // 0x140 shares index 0 with 0x100 and evicts it.
        up(32'h100, 1'b1, 32'h200);
        up(32'h140, 1'b1, 32'h300);
        lk(32'h100);
        pred("alias_old", 1'b0, 32'h104);
        lk(32'h140);
        pred("alias_new", 1'b1, 32'h300);

        // Not-taken miss must not allocate.
        up(32'h108, 1'b0, 32'h900);
        lk(32'h108);
        pred("nt_miss", 1'b0, 32'h10c);

        lk(32'hFFFF_FFFC);
        pred("wrap", 1'b0, 32'h0);

        // Mid-stream reset with a lookup pending: outputs clear, table clears.
        up(32'h100, 1'b1, 32'h200);
        rst = 1'b1;
        lk(32'h100);
        chk("mrst.valid", {31'h0, pred_valid}, 32'h0);
        chk("mrst.taken", {31'h0, pred_taken}, 32'h0);
        chk("mrst.pc", pred_pc, 32'h0);
        chk("mrst.addr", pred_addr, 32'h0);
        rst = 1'b0;
        lk(32'h100);
        pred("post_rst", 1'b0, 32'h104);

        // Same-index update and lookup on an empty entry.
        cyc(1'b1, 32'h180, 1'b1, 32'h180, 1'b1, 32'h400);
`ifdef BP_BYPASS_EN
        pred("same_idx", 1'b1, 32'h400);
`else
        pred("same_idx", 1'b0, 32'h184);
`endif
        lk(32'h180);
        pred("same_idx_next", 1'b1, 32'h400);

        // Different indices proceed independently.
        cyc(1'b1, 32'h180, 1'b1, 32'h104, 1'b1, 32'h500);
        pred("diff_idx", 1'b1, 32'h400);
        lk(32'h106);
        pred("low_bits", 1'b1, 32'h500);
        chk("low_bits.pc", pred_pc, 32'h106);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
